// File: rtl/punt_intercept_nch.sv
// Multi-channel 68020 punt decoder: claims programmable address windows, requests the MCU, ends with DSACK.
// Optional REQ timeout with sticky flag when PUNT_TIMEOUT_EN is defined.
module punt_intercept_nch #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255,
  localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  CLKCPU_A,
  input  logic                  RESET_n,
  input  logic                  AS20,
  input  logic                  RW,
  input  logic [ADDR_W-1:0]     A,
  input  logic [NCH*ADDR_W-1:0] CH_BASE,
  input  logic [NCH*ADDR_W-1:0] CH_MASK,
  input  logic [NCH-1:0]        CH_EN,
  input  logic [NCH-1:0]        CH_RDONLY,
  input  logic                  PUNT_IN,
  output logic                  PUNT_OUT,
  output logic [1:0]            DSACK,
  output logic [NCH-1:0]        REQ,
  input  logic                  ACK_IN,
  output logic [CH_W-1:0]       ACTIVE_CH,
  output logic                  TIMEOUT_FLAG
);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("NCH must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StReq, StTerm, StWaitNeg} state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] active_q, active_d;
  logic [NCH-1:0]  hit;
  logic [CH_W-1:0] winner;
  logic            any_hit;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;
  logic                   ack_rise;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = CH_EN[i]
             && (((A ^ CH_BASE[i*ADDR_W +: ADDR_W]) & CH_MASK[i*ADDR_W +: ADDR_W]) == '0)
             && (RW || !CH_RDONLY[i]);
    end
  end

  // Scan downwards so the lowest matching channel wins.
  always_comb begin
    winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) winner = CH_W'(i);
    end
  end

  assign any_hit  = RESET_n && (|hit);
  assign PUNT_OUT = (!PUNT_IN || any_hit) ? 1'b0 : 1'bz;

  always_ff @(posedge CLKCPU_A) begin
    if (!RESET_n) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ACK_IN};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ack_rise = sync_q[SYNC_STAGES-1] && !sync_dly_q;

`ifdef PUNT_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        flag_q, flag_d;

  assign cnt_inc      = cnt_q + 16'd1;
  assign TIMEOUT_FLAG = flag_q;

  always_ff @(posedge CLKCPU_A) begin
    if (!RESET_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end
`else
  assign TIMEOUT_FLAG = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
`ifdef PUNT_TIMEOUT_EN
    cnt_d    = cnt_q;
    flag_d   = flag_q;
`endif
    case (state_q)
      StIdle: begin
        if (!AS20 && PUNT_IN && any_hit) begin
          state_d  = StReq;
          active_d = winner;
`ifdef PUNT_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StReq: begin
        if (AS20) begin
          state_d  = StIdle;
          active_d = '0;
        end else if (ack_rise) begin
          state_d = StTerm;
        end else begin
`ifdef PUNT_TIMEOUT_EN
          cnt_d = cnt_inc;
          if (cnt_inc == 16'(TIMEOUT)) begin
            state_d = StWaitNeg;
            flag_d  = 1'b1;
          end
`endif
        end
      end
      StTerm, StWaitNeg: begin
        if (AS20) begin
          state_d  = StIdle;
          active_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        active_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLKCPU_A) begin
    if (!RESET_n) begin
      state_q  <= StIdle;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    REQ = '0;
    if (state_q == StReq) REQ[active_q] = 1'b1;
  end

  assign DSACK     = (state_q == StTerm || state_q == StWaitNeg) ? 2'b10 : 2'bzz;
  assign ACTIVE_CH = active_q;

endmodule

// File: tb/tb_punt_intercept_nch.sv
// Scoreboard bench for punt_intercept_nch; released PUNT_OUT/DSACK read as 1 through pull-ups.
module tb_punt_intercept_nch;
  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int SS  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            as20;
  logic            rw;
  logic [AW-1:0]   a;
  logic [NCH*AW-1:0] ch_base;
  logic [NCH*AW-1:0] ch_mask;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  ch_rdonly;
  logic            punt_in;
  wire             punt_out;
  wire  [1:0]      dsack;
  logic [NCH-1:0]  req;
  logic            ack_in;
  logic [1:0]      active_ch;
  logic            timeout_flag;

  pullup (punt_out);
  pullup (dsack[0]);
  pullup (dsack[1]);

  typedef struct packed {
    logic [NCH-1:0] req;
    logic [1:0]     ch;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  punt_intercept_nch #(
    .NCH(NCH), .ADDR_W(AW), .SYNC_STAGES(SS), .TIMEOUT(8)
  ) dut (
    .CLKCPU_A(clk), .RESET_n(rst_n), .AS20(as20), .RW(rw), .A(a),
    .CH_BASE(ch_base), .CH_MASK(ch_mask), .CH_EN(ch_en), .CH_RDONLY(ch_rdonly),
    .PUNT_IN(punt_in), .PUNT_OUT(punt_out), .DSACK(dsack), .REQ(req),
    .ACK_IN(ack_in), .ACTIVE_CH(active_ch), .TIMEOUT_FLAG(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] base, input logic [AW-1:0] mask);
    ch_base[i*AW +: AW] = base;
    ch_mask[i*AW +: AW] = mask;
  endtask

  task automatic expect_owner(input logic [NCH-1:0] r, input logic [1:0] c);
    exp_t e;
    e.req = r;
    e.ch  = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; as20 = 1'b0; rw = 1'b1; a = 24'hDC0004; punt_in = 1'b1;
    tick(); tick();
    checks++; if (req !== 4'b0) begin errors++; $display("FAIL reset_req: got %b want 0000", req); end
    checks++; if (dsack !== 2'b11) begin errors++; $display("FAIL reset_dsack: got %b want released", dsack); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d want 0", active_ch); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", timeout_flag); end
    checks++; if (punt_out !== 1'b1) begin errors++; $display("FAIL reset_punt: got %b want released", punt_out); end
    as20 = 1'b1; rst_n = 1'b1;
    tick();
    // Reset in the middle of an owned cycle must abandon it.
    as20 = 1'b0; expect_owner(4'b0001, 2'd0);
    tick();
    e = exp_q.pop_front();
    checks++; if (req !== e.req) begin errors++; $display("FAIL midreset_req_pre: got %b want %b", req, e.req); end
    rst_n = 1'b0;
    tick();
    checks++; if (req !== 4'b0 || active_ch !== 2'd0) begin
      errors++; $display("FAIL midreset_abandon: got req=%b ch=%0d want 0000/0", req, active_ch);
    end
    as20 = 1'b1; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_ack();
    exp_t e;
    a = 24'hDC0004; rw = 1'b1; as20 = 1'b0;
    expect_owner(4'b0001, 2'd0);
    #1;
    checks++; if (punt_out !== 1'b0) begin errors++; $display("FAIL read_punt: got %b want 0", punt_out); end
    checks++; if (req !== 4'b0) begin errors++; $display("FAIL read_req_early: got %b want 0000", req); end
    tick();
    if (exp_q.size() == 0) begin
      errors++; checks++; $display("FAIL read_sb: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      checks++; if (req !== e.req || active_ch !== e.ch) begin
        errors++; $display("FAIL read_owner: got req=%b ch=%0d want %b/%0d", req, active_ch, e.req, e.ch);
      end
    end
    ack_in = 1'b1;
    repeat (SS) tick();
    checks++; if (dsack !== 2'b11) begin errors++; $display("FAIL read_dsack_early: got %b want released", dsack); end
    tick();
    checks++; if (dsack !== 2'b10) begin errors++; $display("FAIL read_dsack: got %b want 10", dsack); end
    checks++; if (req !== 4'b0) begin errors++; $display("FAIL read_req_term: got %b want 0000", req); end
    as20 = 1'b1;
    tick();
    checks++; if (dsack !== 2'b11 || active_ch !== 2'd0) begin
      errors++; $display("FAIL read_release: got dsack=%b ch=%0d want released/0", dsack, active_ch);
    end
    ack_in = 1'b0;
    repeat (SS + 1) tick();
  endtask

  task automatic test_priority();
    exp_t e;
    set_ch(1, 24'hDFF000, 24'hFFFF00);
    set_ch(2, 24'h123456, 24'hFFFFFF);
    set_ch(3, 24'hDFF00A, 24'hFFFFFF);
    ch_en = 4'b1111;
    a = 24'hDFF00A; rw = 1'b1; as20 = 1'b0;
    expect_owner(4'b0010, 2'd1);
    tick();
    e = exp_q.pop_front();
    checks++; if (req !== e.req || active_ch !== e.ch) begin
      errors++; $display("FAIL prio_owner: got req=%b ch=%0d want %b/%0d", req, active_ch, e.req, e.ch);
    end
    ack_in = 1'b1;
    repeat (SS + 1) tick();
    checks++; if (dsack !== 2'b10) begin errors++; $display("FAIL prio_dsack: got %b want 10", dsack); end
    as20 = 1'b1;
    tick();
    ack_in = 1'b0;
    repeat (SS + 1) tick();
  endtask

  task automatic test_accel_punt();
    punt_in = 1'b0; a = 24'hDC0004; rw = 1'b1; as20 = 1'b0;
    #1;
    checks++; if (punt_out !== 1'b0) begin errors++; $display("FAIL accel_punt: got %b want 0", punt_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req !== 4'b0 || dsack !== 2'b11) begin
        errors++; $display("FAIL accel_idle: got req=%b dsack=%b want 0000/released", req, dsack);
      end
    end
    as20 = 1'b1; punt_in = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    exp_t e;
    a = 24'hDC0004; rw = 1'b1; as20 = 1'b0;
    expect_owner(4'b0001, 2'd0);
    tick();
    e = exp_q.pop_front();
    checks++; if (req !== e.req) begin errors++; $display("FAIL abort_req: got %b want %b", req, e.req); end
    tick();
    as20 = 1'b1;
    tick();
    checks++; if (req !== 4'b0 || dsack !== 2'b11) begin
      errors++; $display("FAIL abort_release: got req=%b dsack=%b want 0000/released", req, dsack);
    end
    ack_in = 1'b1;
    for (int i = 0; i < SS + 2; i++) begin
      tick();
      checks++; if (req !== 4'b0 || dsack !== 2'b11) begin
        errors++; $display("FAIL abort_late_ack: got req=%b dsack=%b want 0000/released", req, dsack);
      end
    end
    ack_in = 1'b0;
    repeat (SS + 1) tick();
    test_read_ack();
  endtask

  task automatic test_rdonly();
    ch_rdonly = 4'b0001; rw = 1'b0; a = 24'hDC0004; as20 = 1'b0;
    #1;
    checks++; if (punt_out !== 1'b1) begin errors++; $display("FAIL rdonly_punt: got %b want released", punt_out); end
    tick(); tick();
    checks++; if (req !== 4'b0) begin errors++; $display("FAIL rdonly_req: got %b want 0000", req); end
    as20 = 1'b1; rw = 1'b1; ch_rdonly = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    a = 24'hDC0004; rw = 1'b1; as20 = 1'b0;
    expect_owner(4'b0001, 2'd0);
    tick();
    e = exp_q.pop_front();
    checks++; if (req !== e.req) begin errors++; $display("FAIL tmo_req: got %b want %b", req, e.req); end
    repeat (7) tick();
    checks++; if (req !== 4'b0001) begin errors++; $display("FAIL tmo_req_held: got %b want 0001", req); end
    tick();
`ifdef PUNT_TIMEOUT_EN
    checks++; if (req !== 4'b0 || dsack !== 2'b10 || timeout_flag !== 1'b1) begin
      errors++; $display("FAIL tmo_fire: got req=%b dsack=%b flag=%b want 0000/10/1", req, dsack, timeout_flag);
    end
    as20 = 1'b1;
    tick(); tick();
    checks++; if (dsack !== 2'b11 || timeout_flag !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: got dsack=%b flag=%b want released/1", dsack, timeout_flag);
    end
`else
    checks++; if (req !== 4'b0001 || dsack !== 2'b11 || timeout_flag !== 1'b0) begin
      errors++; $display("FAIL tmo_none: got req=%b dsack=%b flag=%b want 0001/released/0", req, dsack, timeout_flag);
    end
    as20 = 1'b1;
    tick();
    checks++; if (req !== 4'b0) begin errors++; $display("FAIL tmo_abort: got %b want 0000", req); end
`endif
    rst_n = 1'b0;
    tick();
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", timeout_flag); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ch_base = '0; ch_mask = '0; ch_rdonly = '0; ch_en = 4'b0001; ack_in = 1'b0;
    set_ch(0, 24'hDC0000, 24'hFFFF00);
    test_reset();
    test_read_ack();
    test_priority();
    test_accel_punt();
    test_abort();
    test_rdonly();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
